la_vector_engine: RTL and testbench

On-chip counterpart of the off-chip vector bench for the 16x16 yblock: a Wishbone slave that accepts 100-bit test vectors (52-bit stimulus + 48-bit expected response), drives the stimulus onto the yblock input lanes, waits a settle interval, samples the 48-bit yblock response, compares and counts errors. It sits inside `user_proj_example` between the Wishbone port and the yblock, replacing the logic-analyzer path when the block is tested from the management core.

---
 rtl/la_vector_engine.sv | 211 +++++++++++++++++++++
 tb/tb_la_vector_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_vector_engine.sv
// -----------------------------------------------------------------------------
// la_vector_engine
//
// Wishbone-slave vector tester for the 16x16 yblock. Software loads a 52-bit
// stimulus and a 48-bit expected response, then commits the vector by writing
// EXP_HI. The engine drives the stimulus onto the yblock lanes, waits for the
// response to settle, samples it once, compares it and keeps a count of
// vectors and errors.
//
// Ports
//   wb_clk_i, wb_rst_i     single clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i   Wishbone classic strobe, cycle, write enable
//   wbs_sel_i              byte selects (ignored, all accesses are full-word)
//   wbs_adr_i, wbs_dat_i   address and write data
//   wbs_ack_o, wbs_dat_o   acknowledge and read data (valid together)
//   vec_o[49:0]            stimulus: [49] block reset, [48] config strobe,
//                          [47:32] 16-bit lane, [31:0] 32-bit lane
//   resp_i[47:0]           yblock response
//   busy_o                 a vector is in flight
//   mismatch_o             one-cycle pulse when a checked vector fails
//
// Register map (decode on wbs_adr_i[4:2])
//   0x00 STIM_LO  R/W stim[31:0]
//   0x04 STIM_HI  R/W stim[51:32]; stim[51] skip-check, stim[50] debug flag
//   0x08 EXP_LO   R/W exp[31:0]
//   0x0C EXP_HI   R/W exp[47:32]; writing commits the vector
//   0x10 STATUS   R   [0] busy, [1] last mismatch, [31:16] error count
//   0x14 COUNT    R   [15:0] vectors checked; any write clears counters + flag
//   0x18 RESP_LO  R   last sampled resp[31:0]
//   0x1C RESP_HI  R   last sampled resp[47:32]
// -----------------------------------------------------------------------------
module la_vector_engine #(
  parameter logic [23:0] ADDR_BASE     = 24'h300000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [49:0] vec_o,
  input  logic [47:0] resp_i,
  output logic        busy_o,
  output logic        mismatch_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // The settle counter holds the number of SETTLE cycles still to run,
  // including the current one, so APPLY + SETTLE together span SETTLE_CYCLES.
  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
  localparam bit         SHORT_SETTLE = (SETTLE_CYCLES <= 1);

  localparam logic [2:0] OFF_STIM_LO = 3'd0;
  localparam logic [2:0] OFF_STIM_HI = 3'd1;
  localparam logic [2:0] OFF_EXP_LO  = 3'd2;
  localparam logic [2:0] OFF_EXP_HI  = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  localparam logic [2:0] OFF_COUNT   = 3'd5;
  localparam logic [2:0] OFF_RESP_LO = 3'd6;
  localparam logic [2:0] OFF_RESP_HI = 3'd7;

  state_t      state, state_nxt;
  logic [7:0]  settle_cnt;
  logic        cnt_load, cnt_dec, do_check;

  logic [51:0] stim_q;
  logic [47:0] exp_q;
  logic [47:0] resp_q;
  logic [15:0] err_cnt;
  logic [15:0] vec_cnt;
  logic        mm_flag;

  logic [2:0]  reg_off;
  logic        sel_hit, stallable, wr_stall, accept, wr_en, rd_en, commit;
  logic        check_fail;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[7:5], wbs_adr_i[1:0]};

  // Wishbone classic handshake: a request is stb & cyc & base match. An
  // accepted request in cycle t gives ack (with read data) for exactly cycle
  // t+1; the ~ack term stops a held strobe from being accepted twice. Writes
  // that could disturb a vector in flight (stimulus, expected, COUNT) are
  // simply not accepted while busy, which stretches the master's cycle until
  // the engine is idle again. Reads and read-only writes are never held off.
  assign reg_off   = wbs_adr_i[4:2];
  assign sel_hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == ADDR_BASE) & ~wbs_ack_o;
  assign stallable = (reg_off <= OFF_EXP_HI) || (reg_off == OFF_COUNT);
  assign wr_stall  = wbs_we_i & busy_o & stallable;
  assign accept    = sel_hit & ~wr_stall;
  assign wr_en     = accept & wbs_we_i;
  assign rd_en     = accept & ~wbs_we_i;
  assign commit    = wr_en & (reg_off == OFF_EXP_HI) & (state == IDLE);

  assign busy_o     = (state != IDLE);
  assign check_fail = do_check & ~stim_q[51] & (resp_i != exp_q);

  always_comb begin
    rd_data = 32'h0;
    case (reg_off)
      OFF_STIM_LO: rd_data = stim_q[31:0];
      OFF_STIM_HI: rd_data = {12'h0, stim_q[51:32]};
      OFF_EXP_LO:  rd_data = exp_q[31:0];
      OFF_EXP_HI:  rd_data = {16'h0, exp_q[47:32]};
      OFF_STATUS:  rd_data = {err_cnt, 14'h0, mm_flag, busy_o};
      OFF_COUNT:   rd_data = {16'h0, vec_cnt};
      OFF_RESP_LO: rd_data = resp_q[31:0];
      OFF_RESP_HI: rd_data = {16'h0, resp_q[47:32]};
      default:     rd_data = 32'h0;
    endcase
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state and per-state controls
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_check  = 1'b0;
    case (state)
      IDLE: begin
        if (commit) state_nxt = APPLY;
      end
      APPLY: begin
        if (SHORT_SETTLE) begin
          state_nxt = CHECK;
        end else begin
          state_nxt = SETTLE;
          cnt_load  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_dec = 1'b1;
        if (settle_cnt <= 8'd1) state_nxt = CHECK;
      end
      CHECK: begin
        do_check  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: bus registers, stimulus, counters, response capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      vec_o      <= 50'h0;
      mismatch_o <= 1'b0;
      settle_cnt <= 8'h0;
      stim_q     <= 52'h0;
      exp_q      <= 48'h0;
      resp_q     <= 48'h0;
      err_cnt    <= 16'h0;
      vec_cnt    <= 16'h0;
      mm_flag    <= 1'b0;
    end else begin
      wbs_ack_o  <= accept;
      wbs_dat_o  <= rd_en ? rd_data : 32'h0;
      mismatch_o <= check_fail;

      if (cnt_load)                          settle_cnt <= SETTLE_LOAD;
      else if (cnt_dec && settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;

      if (wr_en) begin
        case (reg_off)
          OFF_STIM_LO: stim_q[31:0]  <= wbs_dat_i;
          OFF_STIM_HI: stim_q[51:32] <= wbs_dat_i[19:0];
          OFF_EXP_LO:  exp_q[31:0]   <= wbs_dat_i;
          OFF_EXP_HI:  exp_q[47:32]  <= wbs_dat_i[15:0];
          OFF_COUNT: begin
            err_cnt <= 16'h0;
            vec_cnt <= 16'h0;
            mm_flag <= 1'b0;
          end
          default: ;
        endcase
      end

      // Stimulus is level: vec_o only changes on a commit.
      if (commit) vec_o <= stim_q[49:0];

      // COUNT writes are held off while busy, so they never meet a check.
      if (do_check) begin
        resp_q  <= resp_i;
        mm_flag <= check_fail;
        if (vec_cnt != 16'hFFFF) vec_cnt <= vec_cnt + 16'h1;
        if (check_fail && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'h1;
      end
    end
  end

endmodule

// File: tb/tb_la_vector_engine.sv
// -----------------------------------------------------------------------------
// tb_la_vector_engine
//
// Directed and randomized checks of la_vector_engine with a behavioural model
// of the vector counters, mismatch flag and captured response.
// -----------------------------------------------------------------------------
module tb_la_vector_engine;

  localparam logic [23:0] BASE   = 24'h300000;
  localparam int          SETTLE = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i  = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [49:0] vec_o;
  logic [47:0] resp_i = 48'h0;
  logic        busy_o;
  logic        mismatch_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          model_vec  = 0;
  int          model_err  = 0;
  bit          model_flag = 1'b0;
  logic [47:0] model_resp = 48'h0;

  la_vector_engine #(
    .ADDR_BASE     (BASE),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .vec_o      (vec_o),
    .resp_i     (resp_i),
    .busy_o     (busy_o),
    .mismatch_o (mismatch_o)
  );

  // Clock
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Bus driver: the request goes out on a falling edge and is held until ack.
  // Returns at the falling edge where ack is seen, with the strobe dropped.
  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, output int waits);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = {BASE, off}; wbs_dat_i = d;
    waits = 0;
    do begin @(negedge wb_clk_i); waits++; end while (!wbs_ack_o && waits < 100);
    chk($sformatf("write_ack_%0h", off), wbs_ack_o, 1'b1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] d, output int waits);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = {BASE, off};
    waits = 0;
    do begin @(negedge wb_clk_i); waits++; end while (!wbs_ack_o && waits < 100);
    chk($sformatf("read_ack_%0h", off), wbs_ack_o, 1'b1);
    d = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
  endtask

  function automatic logic [31:0] model_status();
    return {model_err[15:0], 14'h0, model_flag, 1'b0};
  endfunction

  // Apply the model's rules for one completed vector.
  task automatic model_vector(input logic [51:0] stim, input logic [47:0] expv, input logic [47:0] resp);
    bit fail;
    fail = !stim[51] && (resp != expv);
    if (model_vec < 65535) model_vec++;
    if (fail && model_err < 65535) model_err++;
    model_flag = fail;
    model_resp = resp;
  endtask

  task automatic load_regs(input logic [51:0] stim, input logic [47:0] expv);
    int w;
    wb_write(8'h00, stim[31:0], w);
    wb_write(8'h04, {12'h0, stim[51:32]}, w);
    wb_write(8'h08, expv[31:0], w);
  endtask

  // Full vector: load, commit, watch busy/mismatch timing, check readback.
  task automatic run_vector(input logic [51:0] stim, input logic [47:0] expv, input logic [47:0] resp);
    int          w, busy_len, early;
    bit          fail;
    logic [31:0] d;
    fail   = !stim[51] && (resp != expv);
    resp_i = resp;
    load_regs(stim, expv);
    wb_write(8'h0C, {16'h0, expv[47:32]}, w);
    chk("commit_ack_latency", w, 1);
    chk("vec_o_after_commit", vec_o, stim[49:0]);
    busy_len = 0; early = 0;
    while (busy_o && busy_len < 100) begin
      busy_len++;
      if (mismatch_o) early++;
      @(negedge wb_clk_i);
    end
    chk("busy_length", busy_len, SETTLE + 1);
    chk("no_pulse_while_busy", early, 0);
    chk("mismatch_pulse", mismatch_o, fail);
    @(negedge wb_clk_i);
    chk("mismatch_single_cycle", mismatch_o, 1'b0);
    model_vector(stim, expv, resp);
    wb_read(8'h10, d, w); chk("status", d, model_status());
    wb_read(8'h14, d, w); chk("count", d, {16'h0, model_vec[15:0]});
    wb_read(8'h18, d, w); chk("resp_lo", d, model_resp[31:0]);
    wb_read(8'h1C, d, w); chk("resp_hi", d, {16'h0, model_resp[47:32]});
    chk("vec_o_held", vec_o, stim[49:0]);
  endtask

  initial begin : main
    logic [31:0] d;
    logic [51:0] stim;
    logic [47:0] expv, resp;
    int          w, nack, waits;
    bit          b1, b2;

    // Reset
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    chk("reset_ack", wbs_ack_o, 1'b0);
    chk("reset_dat", wbs_dat_o, 32'h0);
    chk("reset_vec_o", vec_o, 50'h0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_mismatch", mismatch_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wb_read(8'(i * 4), d, w);
      chk($sformatf("reset_read_%0h", i * 4), d, 32'h0);
      chk("read_latency", w, 1);
    end

    // Address outside the base window is not acknowledged
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3001_0010;
    nack = 0;
    repeat (4) begin @(negedge wb_clk_i); if (wbs_ack_o) nack++; end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    chk("foreign_addr_no_ack", nack, 0);

    // Unwritable bits read back as 0
    wb_write(8'h04, 32'hFFFF_FFFF, w);
    wb_read(8'h04, d, w); chk("stim_hi_mask", d, 32'h000F_FFFF);
    wb_write(8'h0C, 32'hFFFF_FFFF, w);
    // that write committed a vector; let it complete and account for it
    stim = 52'hF_FFFF_0000_0000; expv = 48'hFFFF_0000_0000;
    repeat (SETTLE + 2) @(negedge wb_clk_i);
    model_vector(stim, expv, resp_i);
    wb_read(8'h0C, d, w); chk("exp_hi_mask", d, 32'h0000_FFFF);
    wb_write(8'h14, 32'h0, w);
    model_vec = 0; model_err = 0; model_flag = 1'b0;
    wb_read(8'h14, d, w); chk("count_cleared", d, 32'h0);

    // Directed: passing vector
    run_vector(52'h0_0001_FFFF_0000, 48'h0000_0000_FFFF, 48'h0000_0000_FFFF);
    wb_read(8'h14, d, w); chk("directed_count_1", d, 32'h1);
    wb_read(8'h10, d, w); chk("directed_status_pass", d, 32'h0);

    // Directed: failing vector
    run_vector(52'h0_0001_FFFF_0000, 48'h0000_0000_FFFF, 48'h0000_0000_FFFE);
    wb_read(8'h10, d, w); chk("directed_status_fail", d, 32'h0001_0002);
    wb_read(8'h18, d, w); chk("directed_resp_lo", d, 32'h0000_FFFE);

    // Directed: failing response but skip-check set
    run_vector(52'h8_0001_FFFF_0000, 48'h0000_0000_FFFF, 48'h0000_0000_FFFE);
    wb_read(8'h14, d, w); chk("skip_count_3", d, 32'h3);
    wb_read(8'h10, d, w); chk("skip_status", d, 32'h0001_0000);

    // Randomized vectors
    for (int n = 0; n < 16; n++) begin
      stim = {$urandom_range(0, 32'h000F_FFFF), $urandom()};
      expv = {16'($urandom()), $urandom()};
      case ($urandom_range(0, 2))
        0:       resp = expv;
        1:       resp = expv ^ (48'h1 << $urandom_range(0, 47));
        default: resp = {16'($urandom()), $urandom()};
      endcase
      run_vector(stim, expv, resp);
    end

    // Stall: STIM_LO write during SETTLE waits until the engine is idle
    stim = 52'h0_0002_1234_5678; expv = 48'h0000_CAFE_BEEF;
    resp_i = expv;
    load_regs(stim, expv);
    wb_write(8'h0C, {16'h0, expv[47:32]}, w);
    wb_read(8'h10, d, w);
    chk("status_read_in_settle_latency", w, 1);
    chk("status_busy_bit", d[0], 1'b1);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = {BASE, 8'h00}; wbs_dat_i = 32'hA5A5_5A5A;
    b1 = busy_o; b2 = 1'b1; waits = 0;
    do begin
      @(negedge wb_clk_i); waits++;
      if (!wbs_ack_o) begin
        b2 = b1; b1 = busy_o;
        if (!b1) chk("stalled_vec_o_unchanged", vec_o, stim[49:0]);
      end
    end while (!wbs_ack_o && waits < 100);
    chk("stalled_write_acked", wbs_ack_o, 1'b1);
    chk("stall_busy_before", b2, 1'b1);
    chk("stall_idle_cycle_before_ack", b1, 1'b0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    model_vector(stim, expv, expv);
    wb_read(8'h00, d, w); chk("stalled_write_landed", d, 32'hA5A5_5A5A);
    wb_read(8'h14, d, w); chk("stall_count", d, {16'h0, model_vec[15:0]});

    // Writes to read-only registers are acked and ignored
    wb_write(8'h10, 32'hFFFF_FFFF, w); chk("ro_write_latency", w, 1);
    wb_write(8'h18, 32'hFFFF_FFFF, w);
    wb_read(8'h10, d, w); chk("ro_status_unchanged", d, model_status());
    wb_read(8'h18, d, w); chk("ro_resp_unchanged", d, model_resp[31:0]);

    // Saturation: preload near the top, then fail twice more
    @(negedge wb_clk_i);
    force dut.err_cnt = 16'hFFFF;
    force dut.vec_cnt = 16'hFFFE;
    @(negedge wb_clk_i);
    release dut.err_cnt;
    release dut.vec_cnt;
    model_err = 65535; model_vec = 65534;
    run_vector(52'h0_0000_0000_0001, 48'h0, 48'h1);
    run_vector(52'h0_0000_0000_0002, 48'h0, 48'h2);
    wb_read(8'h10, d, w); chk("err_saturated", d, 32'hFFFF_0002);
    wb_read(8'h14, d, w); chk("count_saturated", d, 32'h0000_FFFF);
    wb_write(8'h14, 32'h1234, w);
    model_vec = 0; model_err = 0; model_flag = 1'b0;
    wb_read(8'h10, d, w); chk("clear_status", d, 32'h0);
    wb_read(8'h14, d, w); chk("clear_count", d, 32'h0);

    // Reset during SETTLE aborts the vector
    stim = 52'h0_0003_0000_00FF; expv = 48'h0; resp_i = 48'hFFFF;
    load_regs(stim, expv);
    wb_write(8'h0C, 32'h0, w);
    @(negedge wb_clk_i);
    chk("pre_reset_busy", busy_o, 1'b1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("abort_vec_o", vec_o, 50'h0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_mismatch", mismatch_o, 1'b0);
    wb_rst_i = 1'b0;
    model_resp = 48'h0;
    nack = 0;
    repeat (SETTLE + 4) begin @(negedge wb_clk_i); if (mismatch_o || busy_o) nack++; end
    chk("abort_no_late_activity", nack, 0);
    wb_read(8'h14, d, w); chk("abort_count", d, 32'h0);
    wb_read(8'h10, d, w); chk("abort_status", d, 32'h0);
    wb_read(8'h00, d, w); chk("abort_stim_cleared", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
